// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures rd/data (and PC when WB_TRACE_PC_EN is defined) per
// register-file write, tags each with a sequence number and tracks drops on overflow.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
`ifdef WB_TRACE_PC_EN
    input  logic [31:0]      wb_pc,
`endif
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_data,
    output logic [SEQ_W-1:0] out_seq,
`ifdef WB_TRACE_PC_EN
    output logic [31:0]      out_pc,
`endif
    output logic [$clog2(DEPTH):0] count,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
`ifdef WB_TRACE_PC_EN
        logic [31:0]      pc;
`endif
        logic [SEQ_W-1:0] seq;
        logic [31:0]      data;
        logic [4:0]       rd;
    } entry_t;

    entry_t          mem_q [0:DEPTH-1];
    entry_t          wr_entry, head;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic            wb_event, push, pop, drop, mem_we;

    assign out_valid = (count_q != '0);

    always_comb begin
        wb_event   = wb_valid && (wb_rd != 5'd0);
        pop        = out_valid && out_ready;
        // a full FIFO still accepts an event when the head leaves in the same cycle
        push       = wb_event && ((count_q != FULL_CNT) || pop);
        drop       = wb_event && !push;
        mem_we     = push && !clear;

        wr_entry      = '0;
        wr_entry.rd   = wb_rd;
        wr_entry.data = wb_data;
        wr_entry.seq  = seq_q;
`ifdef WB_TRACE_PC_EN
        wr_entry.pc   = wb_pc;
`endif

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (wb_event) seq_d = seq_q + SEQ_W'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // storage needs no reset: out_* fields are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        out_rd   = out_valid ? head.rd   : '0;
        out_data = out_valid ? head.data : '0;
        out_seq  = out_valid ? head.seq  : '0;
`ifdef WB_TRACE_PC_EN
        out_pc   = out_valid ? head.pc   : '0;
`endif
    end

    assign count    = count_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
endmodule
